mux_n_to_1_pipe: RTL

//  - Parametrised N-input, WIDTH-bit registered selector with a valid/ready handshake on both sides.
//  - Replaces the single-bit-select 32-bit combinational 2:1 operand mux wherever a datapath stage

---
 rtl/mux_n_to_1_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/mux_n_to_1_pipe.sv
// Registered N:1 word selector behind a 2-entry skid buffer with valid/ready on both sides.
// Optional macro MUX_SEL_ERR_EN: drop out-of-range selects and pulse sel_err instead of buffering zero.
module mux_n_to_1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] head_data, skid_data, sel_data;
  logic [SEL_W-1:0] head_sel, skid_sel;
  logic             head_valid, skid_valid;
  logic [WIDTH-1:0] nxt_head_data, nxt_skid_data;
  logic [SEL_W-1:0] nxt_head_sel, nxt_skid_sel;
  logic             nxt_head_valid, nxt_skid_valid;
  logic             accept, pop, store;

  assign accept = in_valid & in_ready;
  assign pop    = head_valid & out_ready;

  // Out-of-range selects match no lane and fall through to an all-zero word.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic sel_ok;
  assign sel_ok = (in_sel <= SEL_W'(NUM_IN - 1));
  assign store  = accept & sel_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err <= 1'b0;
    else     sel_err <= accept & ~sel_ok;
  end
`else
  assign store   = accept;
  assign sel_err = 1'b0;
`endif

  // Head is the oldest word; the skid slot only fills while the head is stalled.
  always_comb begin
    nxt_head_data  = head_data;
    nxt_head_sel   = head_sel;
    nxt_head_valid = head_valid;
    nxt_skid_data  = skid_data;
    nxt_skid_sel   = skid_sel;
    nxt_skid_valid = skid_valid;
    if (pop) begin
      if (skid_valid) begin
        nxt_head_data  = skid_data;
        nxt_head_sel   = skid_sel;
        nxt_skid_valid = store;
        if (store) begin
          nxt_skid_data = sel_data;
          nxt_skid_sel  = in_sel;
        end
      end else begin
        nxt_head_valid = store;
        if (store) begin
          nxt_head_data = sel_data;
          nxt_head_sel  = in_sel;
        end
      end
    end else if (store) begin
      if (!head_valid) begin
        nxt_head_data  = sel_data;
        nxt_head_sel   = in_sel;
        nxt_head_valid = 1'b1;
      end else begin
        nxt_skid_data  = sel_data;
        nxt_skid_sel   = in_sel;
        nxt_skid_valid = 1'b1;
      end
    end
  end

  // in_ready is registered from the next occupancy so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data  <= '0;
      head_sel   <= '0;
      head_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      head_data  <= nxt_head_data;
      head_sel   <= nxt_head_sel;
      head_valid <= nxt_head_valid;
      skid_data  <= nxt_skid_data;
      skid_sel   <= nxt_skid_sel;
      skid_valid <= nxt_skid_valid;
      in_ready   <= ~(nxt_head_valid & nxt_skid_valid);
    end
  end

  assign out_data  = head_data;
  assign out_sel   = head_sel;
  assign out_valid = head_valid;

endmodule
